// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: single-stage registered RV32I immediate generator.
//
// Decodes the opcode of an incoming instruction word, forms the
// sign-extended immediate for its format and presents the result one
// cycle later behind a valid/ready handshake. It also keeps a saturating
// count of accepted words whose opcode is not recognised.
//
// Optional feature macro: IMM_ZICSR_EN. When defined, SYSTEM opcode words
// with funct3[2]=1 decode as fmt 6 (CSR zimm, zero-extended ins[19:15]).
// When undefined, every SYSTEM word decodes as an I-type immediate.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake (in_ready = !out_valid | out_ready)
//   instruction          raw RV32I word
//   out_valid/out_ready  output handshake
//   imm                  extended immediate (XLEN bits)
//   fmt                  0 none, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z, 7 illegal
//   illegal              fmt == 7, qualified by out_valid
//   illegal_cnt          saturating count of accepted illegal words
//   cnt_clr              synchronous clear of illegal_cnt (wins over count)
module imm_gen_pipe #(
  parameter int INSTRUCTION = 32,
  parameter int XLEN        = 32,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INSTRUCTION-1:0] instruction,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        imm,
  output logic [2:0]             fmt,
  output logic                   illegal,
  output logic [CNT_W-1:0]       illegal_cnt,
  input  logic                   cnt_clr
);

  localparam logic [2:0] F_NONE = 3'd0;
  localparam logic [2:0] F_I    = 3'd1;
  localparam logic [2:0] F_S    = 3'd2;
  localparam logic [2:0] F_B    = 3'd3;
  localparam logic [2:0] F_U    = 3'd4;
  localparam logic [2:0] F_J    = 3'd5;
  localparam logic [2:0] F_ILL  = 3'd7;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
  } dec_t;

  logic [31:0]        ins;
  logic signed [31:0] imm32;
  dec_t               dec;
  logic               xfer_in;

  assign ins = instruction[31:0];

  // Every immediate is built 32 bits wide with its sign already in bit 31;
  // the final signed cast then replicates that bit up to XLEN. The zimm
  // case keeps bit 31 clear, so the same cast yields zero extension.
  always_comb begin
    dec.fmt = F_ILL;
    imm32   = '0;
    unique case (ins[6:0])
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin
        dec.fmt = F_I;
        imm32   = {{20{ins[31]}}, ins[31:20]};
      end
      7'b1110011: begin
`ifdef IMM_ZICSR_EN
        if (ins[14]) begin
          dec.fmt = 3'd6;
          imm32   = {27'b0, ins[19:15]};
        end else begin
          dec.fmt = F_I;
          imm32   = {{20{ins[31]}}, ins[31:20]};
        end
`else
        dec.fmt = F_I;
        imm32   = {{20{ins[31]}}, ins[31:20]};
`endif
      end
      7'b0100011: begin
        dec.fmt = F_S;
        imm32   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'b1100011: begin
        dec.fmt = F_B;
        imm32   = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec.fmt = F_U;
        imm32   = {ins[31:12], 12'b0};
      end
      7'b1101111: begin
        dec.fmt = F_J;
        imm32   = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      7'b0110011: dec.fmt = F_NONE;
      default:    dec.fmt = F_ILL;
    endcase
    dec.imm = XLEN'(imm32);
  end

  assign in_ready = !out_valid || out_ready;
  assign xfer_in  = in_valid && in_ready;

  // Output register: load on input transfer, drop valid after an output
  // transfer with nothing new arriving, otherwise hold (stall).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      imm       <= '0;
      fmt       <= F_NONE;
      illegal   <= 1'b0;
    end else if (xfer_in) begin
      out_valid <= 1'b1;
      imm       <= dec.imm;
      fmt       <= dec.fmt;
      illegal   <= (dec.fmt == F_ILL);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      illegal_cnt <= '0;
    else if (cnt_clr)
      illegal_cnt <= '0;
    else if (xfer_in && dec.fmt == F_ILL && illegal_cnt != CNT_MAX)
      illegal_cnt <= illegal_cnt + 1'b1;
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe (XLEN=32, CNT_W=2). The driver pushes
// the reference result of every accepted word; a separate monitor pops and
// compares whenever the DUT hands a result over, and checks that a stalled
// result stays put.
module tb_imm_gen_pipe;
  localparam int XLEN  = 32;
  localparam int CNT_W = 2;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0, cnt_clr = 1'b0;
  logic in_ready, out_valid, illegal;
  logic [31:0] instruction = '0;
  logic [XLEN-1:0] imm;
  logic [2:0] fmt;
  logic [CNT_W-1:0] illegal_cnt;

  imm_gen_pipe #(.INSTRUCTION(32), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .out_valid(out_valid), .out_ready(out_ready),
    .imm(imm), .fmt(fmt), .illegal(illegal), .illegal_cnt(illegal_cnt),
    .cnt_clr(cnt_clr));

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
  } exp_t;

  exp_t q[$];
  int n_tests = 0, n_fail = 0;
  int mcnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: immediate value as a plain integer (weighted bits, sign bit
  // worth a negative power of two), truncated to XLEN at the end.
  function automatic exp_t model(input logic [31:0] w);
    exp_t r;
    logic [63:0] v;
    logic [63:0] s;
    s = w[31] ? 64'd1 : 64'd0;
    v = 64'd0;
    r.fmt = 3'd7;
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F: r.fmt = 3'd1;
      7'h73: begin
        r.fmt = 3'd1;
`ifdef IMM_ZICSR_EN
        if (w[14]) r.fmt = 3'd6;
`endif
      end
      7'h23: r.fmt = 3'd2;
      7'h63: r.fmt = 3'd3;
      7'h37, 7'h17: r.fmt = 3'd4;
      7'h6F: r.fmt = 3'd5;
      7'h33: r.fmt = 3'd0;
      default: r.fmt = 3'd7;
    endcase
    case (r.fmt)
      3'd1: v = 64'(w[30:20]) - s * 2048;
      3'd2: v = 64'(w[30:25]) * 32 + 64'(w[11:7]) - s * 2048;
      3'd3: v = 64'(w[7]) * 2048 + 64'(w[30:25]) * 32 + 64'(w[11:8]) * 2 - s * 4096;
      3'd4: v = 64'(w[30:12]) * 4096 - s * 64'h8000_0000;
      3'd5: v = 64'(w[19:12]) * 4096 + 64'(w[20]) * 2048 + 64'(w[30:21]) * 2
                - s * 64'h10_0000;
      3'd6: v = 64'(w[19:15]);
      default: v = 64'd0;
    endcase
    r.imm = v[XLEN-1:0];
    return r;
  endfunction

  // One cycle of stimulus. Inputs change 1 after the falling edge; the
  // counter is checked against the model (state after all past edges),
  // then the model is advanced for the coming rising edge.
  task automatic cyc(input logic v, input logic [31:0] w, input logic ordy,
                     input logic clr, output logic acc);
    exp_t e;
    @(negedge clk);
    #1;
    in_valid = v; instruction = w; out_ready = ordy; cnt_clr = clr;
    #1;
    chk("illegal_cnt", 64'(illegal_cnt), 64'(mcnt));
    acc = v && in_ready;
    e = model(w);
    if (clr) mcnt = 0;
    else if (acc && e.fmt == 3'd7 && mcnt < int'(CMAX)) mcnt++;
    if (acc) q.push_back(e);
  endtask

  task automatic expect_out(input string name, input logic [2:0] f, input logic [31:0] im);
    chk({name, ".valid"}, 64'(out_valid), 64'd1);
    chk({name, ".fmt"}, 64'(fmt), 64'(f));
    chk({name, ".imm"}, 64'(imm), 64'(im));
  endtask

  // Monitor: samples 3 after the falling edge, when this cycle's out_ready
  // is already driven.
  logic held = 1'b0;
  logic [XLEN-1:0] h_imm;
  logic [2:0] h_fmt;
  logic h_ill;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold.valid", 64'(out_valid), 64'd1);
          chk("hold.imm", 64'(imm), 64'(h_imm));
          chk("hold.fmt", 64'(fmt), 64'(h_fmt));
          chk("hold.illegal", 64'(illegal), 64'(h_ill));
        end
        held = out_valid && !out_ready;
        h_imm = imm; h_fmt = fmt; h_ill = illegal;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_output", 64'd1, 64'd0);
          end else begin
            e = q.pop_front();
            chk("sb.imm", 64'(imm), 64'(e.imm));
            chk("sb.fmt", 64'(fmt), 64'(e.fmt));
            chk("sb.illegal", 64'(illegal), (e.fmt == 3'd7) ? 64'd1 : 64'd0);
          end
        end
      end
    end
  end

  logic [6:0] ops [11] = '{7'h03, 7'h13, 7'h67, 7'h0F, 7'h73, 7'h23,
                           7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};

  initial begin
    logic acc, hv;
    logic [31:0] hw, w;
    // reset state
    #12;
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.imm", 64'(imm), 64'd0);
    chk("rst.fmt", 64'(fmt), 64'd0);
    chk("rst.illegal", 64'(illegal), 64'd0);
    chk("rst.cnt", 64'(illegal_cnt), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    @(negedge clk); #1; rst_n = 1'b1;

    // addi x1,x0,-1
    cyc(1, 32'hFFF00093, 1, 0, acc);
    cyc(0, 32'h0, 1, 0, acc);
    expect_out("addi", 3'd1, 32'hFFFFFFFF);

    // S, B, U back to back
    cyc(1, 32'h00112623, 1, 0, acc);
    cyc(1, 32'hFE000EE3, 1, 0, acc);
    expect_out("sw", 3'd2, 32'h0000000C);
    cyc(1, 32'h123450B7, 1, 0, acc);
    expect_out("beq", 3'd3, 32'hFFFFFFFC);
    cyc(0, 32'h0, 1, 0, acc);
    expect_out("lui", 3'd4, 32'h12345000);

    // csrrwi
    cyc(1, 32'h3002D0F3, 1, 0, acc);
    cyc(0, 32'h0, 1, 0, acc);
`ifdef IMM_ZICSR_EN
    expect_out("csrrwi", 3'd6, 32'h00000005);
`else
    expect_out("csrrwi", 3'd1, 32'h00000300);
`endif

    // stall: second word held by source for 3 cycles
    cyc(1, 32'h00500113, 0, 0, acc);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 32'h0040006F, 0, 0, acc);
      chk("stall.in_ready", 64'(in_ready), 64'd0);
      expect_out("stall", 3'd1, 32'h00000005);
    end
    cyc(1, 32'h0040006F, 1, 0, acc);
    chk("stall.accept", 64'(acc), 64'd1);
    cyc(0, 32'h0, 1, 0, acc);
    expect_out("jal", 3'd5, 32'h00000004);

    // illegal words, counter saturation and clear priority
    cyc(0, 32'h0, 1, 1, acc);
    for (int i = 0; i < 5; i++) cyc(1, 32'h0000007F, 1, 0, acc);
    chk("ill.illegal", 64'(illegal), 64'd1);
    expect_out("ill", 3'd7, 32'h0);
    cyc(1, 32'h0000007F, 1, 1, acc);
    chk("ill.sat", 64'(illegal_cnt), 64'd3);
    cyc(0, 32'h0, 1, 0, acc);
    chk("ill.clr", 64'(illegal_cnt), 64'd0);

    // randomized traffic
    hv = 1'b0; hw = '0;
    for (int i = 0; i < 600; i++) begin
      w = $urandom;
      if ($urandom_range(0, 4) != 0) w[6:0] = ops[$urandom_range(0, 10)];
      if (hv) cyc(1, hw, ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), acc);
      else begin
        hw = w;
        cyc(($urandom_range(0, 9) < 7), w, ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 19) == 0), acc);
      end
      hv = in_valid && !acc;
    end

    // reset asserted during a stall
    cyc(1, 32'h0000007F, 0, 0, acc);
    cyc(1, 32'h0000007F, 0, 0, acc);
    #2;
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", 64'(out_valid), 64'd0);
    chk("midrst.cnt", 64'(illegal_cnt), 64'd0);
    chk("midrst.in_ready", 64'(in_ready), 64'd1);
    q.delete();
    mcnt = 0;
    repeat (2) @(negedge clk);
    #1; rst_n = 1'b1;
    cyc(1, 32'hFFF00093, 1, 0, acc);
    cyc(0, 32'h0, 1, 0, acc);
    expect_out("postrst", 3'd1, 32'hFFFFFFFF);

    // drain with a bounded wait
    for (int i = 0; i < 20 && q.size() != 0; i++) cyc(0, 32'h0, 1, 0, acc);
    @(negedge clk); #4;
    chk("drain.queue_empty", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
